// File: rtl/frame_buf_pkg.sv
// Shared definitions for the burst frame-buffer memory model.
//   state_t    : burst engine states (IDLE / WRITE / READ)
//   DEF_*      : default widths and read latency used by the model
//   clamp_len  : converts a raw burst length field into the number of beats
package frame_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_MAX_BURST  = 8;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_RD_LATENCY = 2;

  // A zero length still moves one beat; anything above the maximum is cut down.
  function automatic int clamp_len(input int len, input int max_burst);
    int eff;
    if (len == 32'sd0) begin
      eff = 32'sd1;
    end else if (len > max_burst) begin
      eff = max_burst;
    end else begin
      eff = len;
    end
    return eff;
  endfunction

endpackage

// File: rtl/frame_mem_rd_pipe.sv
// Read-data delay line: RD_LATENCY stages of valid/data/last.
//   clk, flush     : clock and synchronous flush (empties every stage, zeroes data)
//   in_valid/data/last : beat issued this cycle
//   out_valid/data/last: beat issued RD_LATENCY cycles earlier
//   fill_next      : some stage will hold a valid beat next cycle
// Data registers only load behind a valid beat, so out_data holds the last
// delivered word while out_valid is low.
module frame_mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  fill_next
);

  logic [RD_LATENCY-1:0] vld_r;
  logic [RD_LATENCY-1:0] last_r;
  logic [DATA_WIDTH-1:0] data_r [RD_LATENCY];

  // Shift beats one stage per cycle; flush drops everything in flight
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_r  <= {RD_LATENCY{1'b0}};
      last_r <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld_r[0]  <= in_valid;
      last_r[0] <= in_valid & in_last;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i]  <= vld_r[i-1];
        last_r[i] <= last_r[i-1];
        if (vld_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  // Occupancy after the next shift: the new beat or anything not yet at the output
  always_comb begin
    fill_next = in_valid;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      fill_next = fill_next | vld_r[i];
    end
  end

  assign out_valid = vld_r[RD_LATENCY-1];
  assign out_last  = last_r[RD_LATENCY-1];
  assign out_data  = data_r[RD_LATENCY-1];

endmodule

// File: rtl/frame_mem_burst.sv
// Behavioural frame-buffer memory with burst command/data interface.
//   clk, reset            : clock, synchronous active-high reset (memory kept)
//   wr_req/addr/len, wr_gnt : write burst command, granted by a one-cycle pulse
//   wr_valid/data/be, wr_rdy: write beats, byte-enabled, accepted while wr_rdy
//   rd_req/addr/len, rd_gnt : read burst command, granted by a one-cycle pulse
//   rd_data/valid/last    : read beats, RD_LATENCY cycles after issue
//   busy                  : burst active or read beats still in flight
// Grants are decided in IDLE and presented the following cycle, together with
// the first WRITE/READ cycle; requesters drop their request on seeing the grant.
module frame_mem_burst
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LEN_WIDTH-1:0]    wr_len,
  output logic                    wr_gnt,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_rdy,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [LEN_WIDTH-1:0]    rd_len,
  output logic                    rd_gnt,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    rd_last,
  output logic                    busy
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int SUM_WIDTH = ADDR_WIDTH + LEN_WIDTH + 1;

  state_t                state_r;
  state_t                state_next_s;
  logic                  prio_wr_r;
  logic [ADDR_WIDTH-1:0] base_addr_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  beat_cnt_r;
  logic                  wr_gnt_r;
  logic                  rd_gnt_r;
  logic                  wr_rdy_r;
  logic                  busy_r;

  logic                  grant_wr_s;
  logic                  grant_rd_s;
  logic                  wr_beat_s;
  logic                  rd_issue_s;
  logic                  final_beat_s;
  logic [SUM_WIDTH-1:0]  beat_sum_s;
  logic [ADDR_WIDTH-1:0] beat_addr_s;
  logic                  pipe_fill_next_s;

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Current beat address, wrapping past the top of memory
  always_comb begin
    beat_sum_s  = SUM_WIDTH'(base_addr_r) + SUM_WIDTH'(beat_cnt_r);
    beat_addr_s = ADDR_WIDTH'(beat_sum_s % SUM_WIDTH'(MEM_DEPTH));
  end

  assign final_beat_s = (beat_cnt_r == (len_r - LEN_WIDTH'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s) begin
          state_next_s = ST_WRITE;
        end else if (grant_rd_s) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_valid && final_beat_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (final_beat_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_READ;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-state decode: arbitration in IDLE, beat strobes in WRITE/READ
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    wr_beat_s  = 1'b0;
    rd_issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_req && (prio_wr_r || !rd_req)) begin
          grant_wr_s = 1'b1;
        end else if (rd_req) begin
          grant_rd_s = 1'b1;
        end else begin
          grant_wr_s = 1'b0;
          grant_rd_s = 1'b0;
        end
      end
      ST_WRITE: wr_beat_s  = wr_valid;
      ST_READ:  rd_issue_s = 1'b1;
      default: begin
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
      end
    endcase
  end

  // Command latching, beat counting, round-robin flag and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_wr_r   <= 1'b1;
      base_addr_r <= {ADDR_WIDTH{1'b0}};
      len_r       <= {LEN_WIDTH{1'b0}};
      beat_cnt_r  <= {LEN_WIDTH{1'b0}};
      wr_gnt_r    <= 1'b0;
      rd_gnt_r    <= 1'b0;
      wr_rdy_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      wr_gnt_r <= grant_wr_s;
      rd_gnt_r <= grant_rd_s;
      wr_rdy_r <= (state_next_s == ST_WRITE);
      busy_r   <= (state_next_s != ST_IDLE) || pipe_fill_next_s;
      if (grant_wr_s) begin
        base_addr_r <= wr_addr;
        len_r       <= LEN_WIDTH'(clamp_len(32'(wr_len), MAX_BURST));
        beat_cnt_r  <= {LEN_WIDTH{1'b0}};
        prio_wr_r   <= 1'b0;
      end else if (grant_rd_s) begin
        base_addr_r <= rd_addr;
        len_r       <= LEN_WIDTH'(clamp_len(32'(rd_len), MAX_BURST));
        beat_cnt_r  <= {LEN_WIDTH{1'b0}};
        prio_wr_r   <= 1'b1;
      end else if (wr_beat_s || rd_issue_s) begin
        beat_cnt_r  <= beat_cnt_r + LEN_WIDTH'(1);
      end else begin
        beat_cnt_r  <= beat_cnt_r;
      end
    end
  end

  // Byte-lane memory write; contents are deliberately left alone by reset
  always_ff @(posedge clk) begin
    if (wr_beat_s && !reset) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) begin
          mem_r[beat_addr_s][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read beats sample memory in their issue cycle, so a write accepted one
  // cycle earlier is already visible.
  frame_mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (rd_issue_s),
    .in_data   (mem_r[beat_addr_s]),
    .in_last   (final_beat_s),
    .out_valid (rd_data_valid),
    .out_data  (rd_data),
    .out_last  (rd_last),
    .fill_next (pipe_fill_next_s)
  );

  assign wr_gnt = wr_gnt_r;
  assign rd_gnt = rd_gnt_r;
  assign wr_rdy = wr_rdy_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_frame_mem_burst.sv
// Self-checking bench for frame_mem_burst: directed scenarios plus random
// bursts, read data checked by a scoreboard against a word/byte array model.
module tb_frame_mem_burst;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int MAXB  = 8;
  localparam int LW    = 4;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req, wr_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] wr_len, rd_len;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          wr_gnt, wr_rdy, rd_gnt, rd_data_valid, rd_last, busy;
  logic [DW-1:0] rd_data;

  frame_mem_burst #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .MEM_DEPTH (DEPTH),
    .MAX_BURST (MAXB), .LEN_WIDTH (LW), .RD_LATENCY (LAT)
  ) dut (
    .clk (clk), .reset (reset),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_len (wr_len), .wr_gnt (wr_gnt),
    .wr_valid (wr_valid), .wr_data (wr_data), .wr_be (wr_be), .wr_rdy (wr_rdy),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_len (rd_len), .rd_gnt (rd_gnt),
    .rd_data (rd_data), .rd_data_valid (rd_data_valid), .rd_last (rd_last),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ref_data  [DEPTH];
  logic [3:0]  ref_known [DEPTH];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hold_exp  = 32'h0;
  logic [31:0] hold_mask = 32'hFFFF_FFFF;
  bit          expect_more = 1'b0;
  bit          mon_rst;
  beat_t       mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic int eff_len(input int len);
    if (len == 0) return 1;
    if (len > MAXB) return MAXB;
    return len;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      wq_data.push_back($urandom);
      wq_be.push_back(4'($urandom_range(0, 15)));
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge and score read beats
  always @(posedge clk) begin
    mon_rst = reset;
    #1;
    if (mon_rst) begin
      exp_q.delete();
      hold_exp    = 32'h0;
      hold_mask   = 32'hFFFF_FFFF;
      expect_more = 1'b0;
      check("valid_after_reset", 32'(rd_data_valid), 32'd0);
    end else begin
      if (expect_more) check("beat_gap", 32'(rd_data_valid), 32'd1);
      expect_more = 1'b0;
      if (rd_data_valid) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_b = exp_q.pop_front();
          check("rd_data", rd_data & mon_b.mask, mon_b.data & mon_b.mask);
          check("rd_last", 32'(rd_last), 32'(mon_b.last));
          hold_exp    = mon_b.data;
          hold_mask   = mon_b.mask;
          expect_more = !mon_b.last;
        end
      end else begin
        check("rd_data_hold", rd_data & hold_mask, hold_exp & hold_mask);
      end
    end
  end

  task automatic wait_gnt(output int waited, output logic gw, output logic gr);
    waited = 0;
    while (!(wr_gnt || rd_gnt) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    gw = wr_gnt;
    gr = rd_gnt;
    check("gnt_seen", 32'(gw | gr), 32'd1);
    check("gnt_onehot", 32'(gw & gr), 32'd0);
  endtask

  // Called at the grant negedge; offers beats while wr_rdy (mode 0 random
  // stalls, 1 stall every other cycle, 2 no stalls) and updates the model.
  task automatic write_beats(input int addr, input int n, input int mode);
    int k = 0;
    int guard = 0;
    int a;
    bit v;
    logic [31:0] m;
    while (k < n && guard < 200) begin
      if (wr_rdy) begin
        case (mode)
          0:       v = ($urandom_range(0, 1) == 1);
          1:       v = (guard % 2 == 0);
          default: v = 1'b1;
        endcase
        wr_valid = v;
        if (v) begin
          wr_data = wq_data.pop_front();
          wr_be   = wq_be.pop_front();
          a = (addr + k) % DEPTH;
          m = be_mask(wr_be);
          ref_data[a]  = (ref_data[a] & ~m) | (wr_data & m);
          ref_known[a] = ref_known[a] | wr_be;
          k++;
        end
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    wr_valid = 1'b0;
    check("wr_beats_done", 32'(k), 32'(n));
  endtask

  // Called at the rd_gnt negedge; queues the expected beats from the model.
  task automatic read_beats(input int addr, input int n, input bit lat_chk);
    int a;
    for (int k = 0; k < n; k++) begin
      a = (addr + k) % DEPTH;
      exp_q.push_back('{data: ref_data[a], mask: be_mask(ref_known[a]), last: (k == n - 1)});
    end
    if (lat_chk) begin
      @(negedge clk);
      check("rd_lat_early", 32'(rd_data_valid), 32'd0);
      @(negedge clk);
      check("rd_lat_first", 32'(rd_data_valid), 32'd1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input int addr, input int len, input int mode);
    int w;
    logic gw, gr;
    wr_addr = AW'(addr);
    wr_len  = LW'(len);
    wr_req  = 1'b1;
    wait_gnt(w, gw, gr);
    check("wr_granted", 32'(gw), 32'd1);
    wr_req = 1'b0;
    write_beats(addr, eff_len(len), mode);
    drain();
  endtask

  task automatic do_read(input int addr, input int len);
    int w;
    logic gw, gr;
    rd_addr = AW'(addr);
    rd_len  = LW'(len);
    rd_req  = 1'b1;
    wait_gnt(w, gw, gr);
    check("rd_granted", 32'(gr), 32'd1);
    rd_req = 1'b0;
    read_beats(addr, eff_len(len), 1'b1);
    drain();
  endtask

  // Both requests together: write wins, read follows after one IDLE cycle.
  task automatic both_round(input logic [31:0] d, input logic [3:0] be);
    int w;
    logic gw, gr;
    wq_data.push_back(d);
    wq_be.push_back(be);
    wr_addr = AW'(5); wr_len = LW'(1);
    rd_addr = AW'(5); rd_len = LW'(1);
    wr_req = 1'b1; rd_req = 1'b1;
    wait_gnt(w, gw, gr);
    check("both_first_wr", 32'(gw), 32'd1);
    check("both_first_not_rd", 32'(gr), 32'd0);
    wr_req = 1'b0;
    write_beats(5, 1, 2);
    wait_gnt(w, gw, gr);
    check("both_then_rd", 32'(gr), 32'd1);
    check("both_turnaround", 32'(w), 32'd1);
    rd_req = 1'b0;
    read_beats(5, 1, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, l;
    int w;
    logic gw, gr;
    reset = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    wr_data = '0; wr_be = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_data[i]  = 32'h0;
      ref_known[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
    check("rst_rd_valid", 32'(rd_data_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);

    both_round(32'hDEADBEEF, 4'hF);
    both_round(32'h11223344, 4'h3);

    for (int i = 1; i <= 4; i++) begin
      wq_data.push_back(32'(i));
      wq_be.push_back(4'hF);
    end
    do_write(1022, 4, 1);
    do_read(1022, 4);

    fill_random(8);
    do_write(1020, 12, 0);
    do_read(1020, 0);
    do_read(1020, 12);
    fill_random(1);
    do_write(100, 0, 2);
    do_read(100, 1);

    // Reset during the second issue cycle of an 8-beat read
    rd_addr = AW'(1020); rd_len = LW'(8); rd_req = 1'b1;
    wait_gnt(w, gw, gr);
    check("mid_rst_rd_granted", 32'(gr), 32'd1);
    rd_req = 1'b0;
    read_beats(1020, 8, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd_gnt", 32'(rd_gnt), 32'd0);
    repeat (8) @(negedge clk);
    check("mid_rst_busy_late", 32'(busy), 32'd0);
    do_read(1020, 8);

    for (int it = 0; it < 30; it++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(1012, 1023);
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        fill_random(eff_len(l));
        do_write(a, l, 0);
      end else begin
        do_read(a, l);
      end
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
